// File: rtl/fifo_room_buffer.sv
// Dual-queue sample buffer behind the master FIFO control FSM.
// Queue 1 holds Manor samples and queue 2 holds Cellar samples; each queue reports its empty/full state and occupancy.
module fifo_room_buffer #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en_cw,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] wr_data,
  input  logic          en_cr1,
  input  logic          en_cr2,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_src,
  output logic          hitr1,
  output logic          hitr2,
  output logic          full1,
  output logic          full2,
  output logic [AW:0]   cnt1,
  output logic [AW:0]   cnt2,
  output logic          ovf1,
  output logic          ovf2
);

  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  logic [PW-1:0] wp1, rp1, wp2, rp2;

  logic wr1_c, wr2_c, push1_c, push2_c, pop1_c, pop2_c;

  // Flags are combinational from the registered pointers.
  assign hitr1 = (wp1 == rp1);
  assign hitr2 = (wp2 == rp2);
  assign full1 = (wp1[AW-1:0] == rp1[AW-1:0]) && (wp1[AW] != rp1[AW]);
  assign full2 = (wp2[AW-1:0] == rp2[AW-1:0]) && (wp2[AW] != rp2[AW]);
  assign cnt1  = PW'(wp1 - rp1);
  assign cnt2  = PW'(wp2 - rp2);

  // Clear overrides all traffic; en_cr1 masks en_cr2 even when queue 1 is empty.
  always_comb begin
    wr1_c   = 1'b0;
    wr2_c   = 1'b0;
    push1_c = 1'b0;
    push2_c = 1'b0;
    pop1_c  = 1'b0;
    pop2_c  = 1'b0;
    if (!clear) begin
      wr1_c   = en_cw && (sel == 2'b01);
      wr2_c   = en_cw && (sel == 2'b10);
      push1_c = wr1_c && !full1;
      push2_c = wr2_c && !full2;
      pop1_c  = en_cr1 && !hitr1;
      pop2_c  = !en_cr1 && en_cr2 && !hitr2;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push1_c) mem1[wp1[AW-1:0]] <= wr_data;
    if (push2_c) mem2[wp2[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp1      <= '0;
      rp1      <= '0;
      wp2      <= '0;
      rp2      <= '0;
      ovf1     <= 1'b0;
      ovf2     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_src   <= 1'b0;
    end else if (clear) begin
      wp1      <= '0;
      rp1      <= '0;
      wp2      <= '0;
      rp2      <= '0;
      ovf1     <= 1'b0;
      ovf2     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (push1_c) wp1 <= PW'(wp1 + PW'(1));
      if (push2_c) wp2 <= PW'(wp2 + PW'(1));
      if (wr1_c && full1) ovf1 <= 1'b1;
      if (wr2_c && full2) ovf2 <= 1'b1;
      rd_valid <= pop1_c || pop2_c;
      if (pop1_c) begin
        rd_data <= mem1[rp1[AW-1:0]];
        rd_src  <= 1'b0;
        rp1     <= PW'(rp1 + PW'(1));
      end else if (pop2_c) begin
        rd_data <= mem2[rp2[AW-1:0]];
        rd_src  <= 1'b1;
        rp2     <= PW'(rp2 + PW'(1));
      end
    end
  end

endmodule

// File: tb/tb_fifo_room_buffer.sv
// Directed self-checking bench for fifo_room_buffer.
module tb_fifo_room_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          en_cw;
  logic [1:0]    sel;
  logic [DW-1:0] wr_data;
  logic          en_cr1;
  logic          en_cr2;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_src;
  logic          hitr1, hitr2, full1, full2, ovf1, ovf2;
  logic [AW:0]   cnt1, cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_room_buffer #(.DW(DW), .DEPTH(16), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .en_cw(en_cw), .sel(sel),
    .wr_data(wr_data), .en_cr1(en_cr1), .en_cr2(en_cr2),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_src(rd_src),
    .hitr1(hitr1), .hitr2(hitr2), .full1(full1), .full2(full2),
    .cnt1(cnt1), .cnt2(cnt2), .ovf1(ovf1), .ovf2(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] q, input logic [DW-1:0] d);
    en_cw   = 1'b1;
    sel     = q;
    wr_data = d;
    tick();
    en_cw = 1'b0;
    sel   = 2'b00;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; en_cw = 1'b0; sel = 2'b00;
    wr_data = '0; en_cr1 = 1'b0; en_cr2 = 1'b0;
    #12;
    check_eq("rst_hitr1", 32'(hitr1), 32'd1);
    check_eq("rst_hitr2", 32'(hitr2), 32'd1);
    check_eq("rst_cnt1", 32'(cnt1), 32'd0);
    check_eq("rst_cnt2", 32'(cnt2), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_ovf", 32'({ovf1, ovf2, full1, full2}), 32'd0);
    rst = 1'b1;
    tick();

    // Write then drain queue 1.
    push(2'b01, 8'h11);
    push(2'b01, 8'h22);
    push(2'b01, 8'h33);
    check_eq("q1_cnt3", 32'(cnt1), 32'd3);
    check_eq("q1_not_empty", 32'(hitr1), 32'd0);
    en_cr1 = 1'b1;
    tick();
    check_eq("q1_pop0_data", 32'(rd_data), 32'h11);
    check_eq("q1_pop0_valid", 32'(rd_valid), 32'd1);
    check_eq("q1_pop0_src", 32'(rd_src), 32'd0);
    check_eq("q1_pop0_hitr1", 32'(hitr1), 32'd0);
    tick();
    check_eq("q1_pop1_data", 32'(rd_data), 32'h22);
    tick();
    check_eq("q1_pop2_data", 32'(rd_data), 32'h33);
    check_eq("q1_pop2_valid", 32'(rd_valid), 32'd1);
    check_eq("q1_pop2_hitr1", 32'(hitr1), 32'd1);
    check_eq("q1_hitr2", 32'(hitr2), 32'd1);
    tick();
    check_eq("q1_empty_pop_valid", 32'(rd_valid), 32'd0);
    check_eq("q1_empty_pop_data", 32'(rd_data), 32'h33);
    check_eq("q1_empty_pop_cnt", 32'(cnt1), 32'd0);
    en_cr1 = 1'b0;

    // Overflow queue 2 with 17 writes, then drain.
    for (int i = 0; i < 17; i++) begin
      push(2'b10, 8'(i + 1));
      if (i == 15) begin
        check_eq("q2_full_at16", 32'(full2), 32'd1);
        check_eq("q2_cnt16", 32'(cnt2), 32'd16);
        check_eq("q2_no_ovf_at16", 32'(ovf2), 32'd0);
      end
    end
    check_eq("q2_ovf_at17", 32'(ovf2), 32'd1);
    check_eq("q2_cnt_after17", 32'(cnt2), 32'd16);
    check_eq("q1_ovf_clean", 32'(ovf1), 32'd0);
    en_cr2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("q2_drain%0d_data", i), 32'(rd_data), 32'(i + 1));
      check_eq($sformatf("q2_drain%0d_src", i), 32'(rd_src), 32'd1);
    end
    en_cr2 = 1'b0;
    check_eq("q2_drained_hitr2", 32'(hitr2), 32'd1);
    check_eq("q2_ovf_sticky", 32'(ovf2), 32'd1);

    // Pop priority.
    push(2'b01, 8'hA1);
    push(2'b10, 8'hB1);
    push(2'b10, 8'hB2);
    en_cr1 = 1'b1; en_cr2 = 1'b1;
    tick();
    check_eq("prio_data", 32'(rd_data), 32'hA1);
    check_eq("prio_src", 32'(rd_src), 32'd0);
    check_eq("prio_cnt2", 32'(cnt2), 32'd2);
    tick();
    check_eq("prio_mask_valid", 32'(rd_valid), 32'd0);
    check_eq("prio_mask_cnt2", 32'(cnt2), 32'd2);
    en_cr1 = 1'b0; en_cr2 = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_cnt2", 32'(cnt2), 32'd0);
    check_eq("clear_ovf2", 32'(ovf2), 32'd0);

    // Wrap-around with interleaved push/pop on queue 1.
    for (int i = 0; i < 40; i++) begin
      push(2'b01, 8'(i * 3 + 5));
      check_eq($sformatf("wrap%0d_cnt", i), 32'(cnt1), 32'd1);
      en_cr1 = 1'b1;
      tick();
      en_cr1 = 1'b0;
      check_eq($sformatf("wrap%0d_data", i), 32'(rd_data), 32'(8'(i * 3 + 5)));
    end
    check_eq("wrap_end_hitr1", 32'(hitr1), 32'd1);

    // Simultaneous push and pop with five entries.
    for (int i = 0; i < 5; i++) push(2'b01, 8'(8'h50 + i));
    en_cw = 1'b1; sel = 2'b01; wr_data = 8'h99; en_cr1 = 1'b1;
    tick();
    en_cw = 1'b0; sel = 2'b00; en_cr1 = 1'b0;
    check_eq("pushpop_cnt", 32'(cnt1), 32'd5);
    check_eq("pushpop_data", 32'(rd_data), 32'h50);
    check_eq("pushpop_valid", 32'(rd_valid), 32'd1);

    // Clear while draining.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) push(2'b01, 8'(8'h61 + i));
    en_cr1 = 1'b1;
    tick();
    check_eq("cdrain_pop0", 32'(rd_data), 32'h61);
    tick();
    check_eq("cdrain_pop1", 32'(rd_data), 32'h62);
    clear = 1'b1;
    tick();
    clear = 1'b0; en_cr1 = 1'b0;
    check_eq("cdrain_hitr1", 32'(hitr1), 32'd1);
    check_eq("cdrain_cnt1", 32'(cnt1), 32'd0);
    check_eq("cdrain_valid", 32'(rd_valid), 32'd0);
    check_eq("cdrain_data_hold", 32'(rd_data), 32'h62);

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 4; i++) push(2'b01, 8'(8'h71 + i));
    en_cr1 = 1'b1;
    tick();
    check_eq("arst_pre_data", 32'(rd_data), 32'h71);
    #3;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 32'(rd_valid), 32'd0);
    check_eq("arst_data", 32'(rd_data), 32'd0);
    check_eq("arst_cnt1", 32'(cnt1), 32'd0);
    check_eq("arst_hitr1", 32'(hitr1), 32'd1);
    en_cr1 = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    check_eq("arst_post_cnt1", 32'(cnt1), 32'd0);
    check_eq("arst_post_valid", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
